// File: rtl/tx_symbol_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tx_symbol_scheduler
// Description : Transmit-side symbol sequencer in front of the 8b/10b encoder.
//               Round-robin shares the encoder between two packet sources,
//               inserts periodic SKP ordered sets between packets and fills
//               unused cycles with the idle data symbol.
//               Optional compliance pattern generator is compiled in when the
//               macro TX_COMPLIANCE_PATTERN_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_symbol_scheduler #(
  parameter int         SKP_INTERVAL = 1180,  // 16..4095
  parameter int         SKP_COUNT    = 3,     // 1..5
  parameter logic [7:0] IDLE_SYM     = 8'h00
) (
  input  logic       INTERCLK,
  input  logic       Reset,
  input  logic       src0_valid,
  input  logic [7:0] src0_data,
  input  logic       src0_k,
  input  logic       src0_last,
  output logic       src0_ready,
  input  logic       src1_valid,
  input  logic [7:0] src1_data,
  input  logic       src1_k,
  input  logic       src1_last,
  output logic       src1_ready,
  input  logic       compliance_req,
  output logic [7:0] TXDATA,
  output logic       TXDATAK,
  output logic       TXCOMP,
  output logic       skp_active,
  output logic       err_underrun
);

  localparam int         TIMER_W   = 12;
  localparam int         CNT_W     = 3;
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(SKP_INTERVAL - 1);
  localparam logic [CNT_W-1:0]   SKP_LAST  = CNT_W'(SKP_COUNT - 1);
  localparam logic [7:0] COM_SYM   = 8'hBC;   // K28.5
  localparam logic [7:0] SKP_SYM   = 8'h1C;   // K28.0
  localparam logic [7:0] D21_5_SYM = 8'hB5;
  localparam logic [7:0] D10_2_SYM = 8'h4A;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_SKP_COM = 3'd2,
    ST_SKP_SYM = 3'd3,
    ST_COMPL   = 3'd4
  } state_t;

  state_t             state;
  logic               owner;        // 0 = src0, 1 = src1 while in SEND
  logic               rr_ptr;       // source favoured at the next grant
  logic               send_entry;   // first SEND cycle after a grant
  logic [CNT_W-1:0]   skp_cnt;
  logic [1:0]         compl_phase;
  logic [TIMER_W-1:0] skp_timer;
  logic               skp_pending;
  logic               timer_wrap;
  logic               compl_go;

  logic               cur_valid;
  logic [7:0]         cur_data;
  logic               cur_k;
  logic               cur_last;

`ifdef TX_COMPLIANCE_PATTERN_EN
  assign compl_go = compliance_req;
`else
  logic unused_compliance;
  assign unused_compliance = compliance_req;
  assign compl_go          = 1'b0;
`endif

  // Selected source, as seen by the SEND state
  assign cur_valid = owner ? src1_valid : src0_valid;
  assign cur_data  = owner ? src1_data  : src0_data;
  assign cur_k     = owner ? src1_k     : src0_k;
  assign cur_last  = owner ? src1_last  : src0_last;

  // Readiness depends on state only so sources never see a valid->ready loop
  assign src0_ready = (state == ST_SEND) && !send_entry && !owner;
  assign src1_ready = (state == ST_SEND) && !send_entry &&  owner;

  assign timer_wrap = (skp_timer == TIMER_MAX);

  // Free-running SKP interval timer; a wrap leaves at most one pending request
  always_ff @(posedge INTERCLK or negedge Reset) begin
    if (!Reset) begin
      skp_timer   <= '0;
      skp_pending <= 1'b0;
    end else begin
      skp_timer <= timer_wrap ? '0 : skp_timer + 1'b1;
      if (timer_wrap)
        skp_pending <= 1'b1;
      else if (state == ST_SKP_COM)
        skp_pending <= 1'b0;
    end
  end

  // Scheduler FSM with registered encoder-side outputs
  always_ff @(posedge INTERCLK or negedge Reset) begin
    if (!Reset) begin
      state        <= ST_IDLE;
      owner        <= 1'b0;
      rr_ptr       <= 1'b0;
      send_entry   <= 1'b0;
      skp_cnt      <= '0;
      compl_phase  <= 2'd0;
      TXDATA       <= IDLE_SYM;
      TXDATAK      <= 1'b0;
      TXCOMP       <= 1'b0;
      skp_active   <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      TXDATA     <= IDLE_SYM;
      TXDATAK    <= 1'b0;
      TXCOMP     <= 1'b0;
      skp_active <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (compl_go) begin
            state       <= ST_COMPL;
            compl_phase <= 2'd0;
          end else if (skp_pending) begin
            state <= ST_SKP_COM;
          end else if (src0_valid || src1_valid) begin
            state      <= ST_SEND;
            send_entry <= 1'b1;
            if (rr_ptr)
              owner <= src1_valid ? 1'b1 : 1'b0;
            else
              owner <= src0_valid ? 1'b0 : 1'b1;
          end
        end

        ST_SEND: begin
          if (send_entry) begin
            // Grant bubble: idle symbol goes out, first beat follows
            send_entry <= 1'b0;
          end else if (cur_valid) begin
            TXDATA  <= cur_data;
            TXDATAK <= cur_k;
            if (cur_last) begin
              rr_ptr <= ~owner;
              state  <= skp_pending ? ST_SKP_COM : ST_IDLE;
            end
          end else begin
            // Source starved mid-packet: pad with idle and flag it
            err_underrun <= 1'b1;
          end
        end

        ST_SKP_COM: begin
          TXDATA     <= COM_SYM;
          TXDATAK    <= 1'b1;
          skp_active <= 1'b1;
          skp_cnt    <= '0;
          state      <= ST_SKP_SYM;
        end

        ST_SKP_SYM: begin
          TXDATA     <= SKP_SYM;
          TXDATAK    <= 1'b1;
          skp_active <= 1'b1;
          if (skp_cnt == SKP_LAST)
            state <= ST_IDLE;
          else
            skp_cnt <= skp_cnt + 1'b1;
        end

`ifdef TX_COMPLIANCE_PATTERN_EN
        ST_COMPL: begin
          case (compl_phase)
            2'd0: begin
              TXDATA  <= COM_SYM;
              TXDATAK <= 1'b1;
              TXCOMP  <= 1'b1;
            end
            2'd1: TXDATA <= D21_5_SYM;
            2'd2: begin
              TXDATA  <= COM_SYM;
              TXDATAK <= 1'b1;
            end
            default: TXDATA <= D10_2_SYM;
          endcase
          compl_phase <= compl_phase + 2'd1;
          // Leave only on a set boundary once the request has gone away
          if (compl_phase == 2'd3 && !compliance_req)
            state <= ST_IDLE;
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
